window_buffer: RTL

WINDOW_BUFFER -- requirements
Module: window_buffer

---
 rtl/cartoon_pkg.sv | 26 ++
 rtl/line_buffer.sv | 37 +++
 rtl/window_buffer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cartoon_pkg.sv
// ---------------------------------------------------------------------------
// cartoon_pkg
// Shared types for the 3x3 window buffer: pixel and window containers, the
// handshake FSM state encoding and a helper that extracts one pixel from a
// packed window.
// Window packing: p0 (top-left) at [215:192] ... p8 (bottom-right) at [23:0].
// ---------------------------------------------------------------------------
package cartoon_pkg;

   localparam int PIX_W = 24;

   typedef logic [PIX_W-1:0]   pixel_t;
   typedef logic [9*PIX_W-1:0] window_t;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2
   } state_t;

   // Pixel k (0..8, row-major) of a packed window.
   function automatic pixel_t win_pix(input window_t w, input int unsigned k);
      return w[(8-k)*PIX_W +: PIX_W];
   endfunction

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image row of pixels. A single address serves both the read and the
// write of a cycle; the read returns the entry as it was before this cycle's
// write, so the caller sees the pixel from the previous row at that column.
// Contents are not reset.
// Ports:
//   clk        clock
//   we_i       write enable (one pixel transfer)
//   addr_i     column index
//   wr_data_i  pixel written at addr_i
//   rd_data_o  previous contents at addr_i (combinational)
// ---------------------------------------------------------------------------
module line_buffer
   import cartoon_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [PIX_W-1:0] wr_data_i,
   output logic [PIX_W-1:0] rd_data_o
);

   pixel_t mem_q [DEPTH];

   assign rd_data_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/window_buffer.sv
// ---------------------------------------------------------------------------
// window_buffer
// Accepts a raster pixel stream and issues every 3x3 neighbourhood whose
// centre is not on the image border, one at a time, with a ready/done
// handshake towards the consumer.
// Optional feature macro: EDGE_FLAG_EN -- when defined, isEdge reports a
// green-channel gradient test on each issued window; otherwise it is tied 0.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pixel_valid/pixel_in  upstream pixel offer ({r,g,b})
//   pixel_ready           block accepts pixel_in this cycle
//   pixelData             issued 3x3 window (p0 at MSBs, p8 at LSBs)
//   mean_average_enable   one-cycle pulse: pixelData/isEdge valid
//   isEdge                edge flag for the window centre
//   pixel_done            consumer finished with the current window
//   frame_done            pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module window_buffer
   import cartoon_pkg::*;
#(
   parameter int         IMG_WIDTH   = 640,
   parameter int         IMG_HEIGHT  = 480,
   parameter logic [8:0] EDGE_THRESH = 9'd64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pixel_valid,
   input  logic [23:0]    pixel_in,
   output logic           pixel_ready,
   output logic [215:0]   pixelData,
   output logic           mean_average_enable,
   output logic           isEdge,
   input  logic           pixel_done,
   output logic           frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   window_t       win_q, win_d;
   window_t       pixel_data_q;
   logic          frame_done_q;

   logic          xfer;
   logic          complete;
   pixel_t        rd_r1;   // row r-1 at this column
   pixel_t        rd_r2;   // row r-2 at this column

   assign xfer     = pixel_valid & pixel_ready;
   // Border centres are never issued: the completing pixel must be at least
   // two rows and two columns in.
   assign complete = xfer && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

   // ---- line buffers: incoming pixel -> row r-1, displaced entry -> row r-2
   line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_r1 (
      .clk       (clk),
      .we_i      (xfer),
      .addr_i    (col_q),
      .wr_data_i (pixel_in),
      .rd_data_o (rd_r1)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_r2 (
      .clk       (clk),
      .we_i      (xfer),
      .addr_i    (col_q),
      .wr_data_i (rd_r1),
      .rd_data_o (rd_r2)
   );

   // ---- raster position counters
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (xfer) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // ---- window shifts left; new right column is {row r-2, row r-1, pixel}
   always_comb begin
      win_d = win_q;
      if (xfer) begin
         win_d = {win_pix(win_q, 1), win_pix(win_q, 2), rd_r2,
                  win_pix(win_q, 4), win_pix(win_q, 5), rd_r1,
                  win_pix(win_q, 7), win_pix(win_q, 8), pixel_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         pixel_data_q <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         frame_done_q <= xfer && (col_q == COL_LAST) && (row_q == ROW_LAST);
         if (complete) begin
            pixel_data_q <= win_d;
         end
      end
   end

   assign pixelData  = pixel_data_q;
   assign frame_done = frame_done_q;

   // ---- handshake FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCEPT;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- handshake FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCEPT:  if (complete)   state_d = ISSUE;
         ISSUE:                   state_d = WAIT;
         WAIT:    if (pixel_done) state_d = ACCEPT;
         default:                 state_d = ACCEPT;
      endcase
   end

   // ---- handshake FSM: outputs
   always_comb begin
      pixel_ready         = 1'b0;
      mean_average_enable = 1'b0;
      case (state_q)
         ACCEPT:  pixel_ready         = 1'b1;
         ISSUE:   mean_average_enable = 1'b1;
         default: ;
      endcase
   end

`ifdef EDGE_FLAG_EN
   logic is_edge_q;

   function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
   endfunction

   // Vertical (g1,g7) plus horizontal (g3,g5) green gradient around p4.
   function automatic logic edge_of(input window_t w);
      logic [8:0] sum;
      sum = abs_diff(w[183:176], w[39:32]) + abs_diff(w[135:128], w[87:80]);
      return sum > EDGE_THRESH;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_edge_q <= 1'b0;
      end else if (complete) begin
         is_edge_q <= edge_of(win_d);
      end
   end

   assign isEdge = is_edge_q;
`else
   assign isEdge = 1'b0;
`endif

endmodule
